// File: rtl/prefix_subtractor_pipe_pkg.sv
// Shared definitions for the pipelined Sklansky subtractor.
// Optional feature macro: SUB_OVF_EN (adds the signed-overflow MSB pipeline).
package prefix_subtractor_pipe_pkg;

    localparam int SUB_SIZE_DEF  = 128;
    localparam int SUB_LEVEL_DEF = 7;

    // Operand width must be an exact power of two matching the level count.
    function automatic bit size_level_ok(input int size, input int level);
        return size == (1 << level);
    endfunction

    // Control part of the per-stage record; G/P vectors travel beside it.
    typedef struct packed {
        logic valid;
`ifdef SUB_OVF_EN
        logic a_msb;
        logic b_msb;
`endif
    } stage_ctl_t;

endpackage

// File: rtl/prefix_subtractor_pipe_prefix_level_stage.sv
// One Sklansky prefix level plus its pipeline register.
// Position 0 of g/p carries the inverted borrow-in; bit SIZE passes untouched.
// Optional feature macro: SUB_OVF_EN (operand MSBs ride in the control record).
module prefix_level_stage
    import prefix_subtractor_pipe_pkg::*;
#(
    parameter int SIZE = SUB_SIZE_DEF,
    parameter int M    = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  stage_ctl_t      ctl_i,
    input  logic [SIZE:0]   g_i,
    input  logic [SIZE:0]   p_i,
    input  logic [SIZE:1]   hs_i,
    output stage_ctl_t      ctl_o,
    output logic [SIZE:0]   g_o,
    output logic [SIZE:0]   p_o,
    output logic [SIZE:1]   hs_o
);

    localparam int BLK  = 1 << M;
    localparam int HALF = BLK / 2;

    logic [SIZE:0] lvl_g;
    logic [SIZE:0] lvl_p;

    stage_ctl_t    ctl_d, ctl_q;
    logic [SIZE:0] g_d, g_q;
    logic [SIZE:0] p_d, p_q;
    logic [SIZE:1] hs_d, hs_q;

    // Level M: upper half of each 2**M block absorbs the top bit of its lower half.
    always_comb begin
        lvl_g = g_i;
        lvl_p = p_i;
        for (int j = 0; j < SIZE; j++) begin
            if ((j % BLK) >= HALF) begin
                lvl_g[j] = g_i[j] | (p_i[j] & g_i[(j / BLK) * BLK + HALF - 1]);
                lvl_p[j] = p_i[j] & p_i[(j / BLK) * BLK + HALF - 1];
            end
        end
    end

    // Next-state: advance when enabled, otherwise hold.
    always_comb begin
        ctl_d = ctl_q;
        g_d   = g_q;
        p_d   = p_q;
        hs_d  = hs_q;
        if (en) begin
            ctl_d = ctl_i;
            g_d   = lvl_g;
            p_d   = lvl_p;
            hs_d  = hs_i;
        end
    end

    // Stage register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_q <= '0;
            g_q   <= '0;
            p_q   <= '0;
            hs_q  <= '0;
        end else begin
            ctl_q <= ctl_d;
            g_q   <= g_d;
            p_q   <= p_d;
            hs_q  <= hs_d;
        end
    end

    assign ctl_o = ctl_q;
    assign g_o   = g_q;
    assign p_o   = p_q;
    assign hs_o  = hs_q;

endmodule

// File: rtl/prefix_subtractor_pipe.sv
// Pipelined Sklansky subtractor: diff = a - b - bin, borrow-out, LEVEL+2 stages.
// Computed as a + ~b + ~bin. Whole pipe stalls together on output backpressure.
// Handshake: a beat moves when valid and ready are both high at a rising edge;
// a presented result holds steady until accepted; in_ready depends only on
// out_valid/out_ready.
// Optional feature macro: SUB_OVF_EN (adds the ovf port and its MSB pipeline).
module prefix_subtractor_pipe
    import prefix_subtractor_pipe_pkg::*;
#(
    parameter int SIZE  = SUB_SIZE_DEF,
    parameter int LEVEL = SUB_LEVEL_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE:1]   a,
    input  logic [SIZE:1]   b,
    input  logic            bin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE:1]   diff,
    output logic            bout
`ifdef SUB_OVF_EN
    ,
    output logic            ovf
`endif
);

    if (!size_level_ok(SIZE, LEVEL)) begin : g_bad_cfg
        $error("prefix_subtractor_pipe: SIZE must equal 2**LEVEL");
    end

    logic stall;
    logic adv;

    // Stage 0 registers (bitwise g/p, borrow-in folded into position 0).
    stage_ctl_t    s0_ctl_d, s0_ctl_q;
    logic [SIZE:0] s0_g_d, s0_g_q;
    logic [SIZE:0] s0_p_d, s0_p_q;
    logic [SIZE:1] s0_hs_d, s0_hs_q;

    // Inter-stage buses, index m is the output of level m.
    stage_ctl_t    ctl_w [0:LEVEL];
    logic [SIZE:0] g_w   [0:LEVEL];
    logic [SIZE:0] p_w   [0:LEVEL];
    logic [SIZE:1] hs_w  [0:LEVEL];

    // Output registers.
    logic          out_valid_d, out_valid_q;
    logic [SIZE:1] diff_d, diff_q;
    logic          bout_d, bout_q;
`ifdef SUB_OVF_EN
    logic          ovf_d, ovf_q;
`endif

    // Final group propagate is not needed for the sum bits.
    logic unused_final_p;
    assign unused_final_p = ^p_w[LEVEL];

    assign stall    = out_valid_q & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = ~stall;

    // Stage 0: form bitwise generate/propagate of a + ~b + ~bin.
    always_comb begin
        s0_ctl_d = s0_ctl_q;
        s0_g_d   = s0_g_q;
        s0_p_d   = s0_p_q;
        s0_hs_d  = s0_hs_q;
        if (adv) begin
            s0_ctl_d.valid = in_valid;
`ifdef SUB_OVF_EN
            s0_ctl_d.a_msb = a[SIZE];
            s0_ctl_d.b_msb = b[SIZE];
`endif
            s0_g_d  = {a & ~b, ~bin};
            s0_p_d  = {~(a ^ b), 1'b0};
            s0_hs_d = ~(a ^ b);
        end
    end

    // Stage 0 register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_ctl_q <= '0;
            s0_g_q   <= '0;
            s0_p_q   <= '0;
            s0_hs_q  <= '0;
        end else begin
            s0_ctl_q <= s0_ctl_d;
            s0_g_q   <= s0_g_d;
            s0_p_q   <= s0_p_d;
            s0_hs_q  <= s0_hs_d;
        end
    end

    assign ctl_w[0] = s0_ctl_q;
    assign g_w[0]   = s0_g_q;
    assign p_w[0]   = s0_p_q;
    assign hs_w[0]  = s0_hs_q;

    for (genvar m = 1; m <= LEVEL; m++) begin : g_level
        prefix_level_stage #(
            .SIZE (SIZE),
            .M    (m)
        ) u_level (
            .clk   (clk),
            .rst   (rst),
            .en    (adv),
            .ctl_i (ctl_w[m-1]),
            .g_i   (g_w[m-1]),
            .p_i   (p_w[m-1]),
            .hs_i  (hs_w[m-1]),
            .ctl_o (ctl_w[m]),
            .g_o   (g_w[m]),
            .p_o   (p_w[m]),
            .hs_o  (hs_w[m])
        );
    end

    // Final stage: sum bits from half-sum and incoming group carry, borrow-out.
    always_comb begin
        out_valid_d = out_valid_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
`ifdef SUB_OVF_EN
        ovf_d       = ovf_q;
`endif
        if (adv) begin
            out_valid_d = ctl_w[LEVEL].valid;
            if (ctl_w[LEVEL].valid) begin
                diff_d = hs_w[LEVEL] ^ g_w[LEVEL][SIZE-1:0];
                bout_d = ~(g_w[LEVEL][SIZE] | (hs_w[LEVEL][SIZE] & g_w[LEVEL][SIZE-1]));
`ifdef SUB_OVF_EN
                ovf_d  = (ctl_w[LEVEL].a_msb ^ ctl_w[LEVEL].b_msb) &
                         (ctl_w[LEVEL].a_msb ^ diff_d[SIZE]);
`endif
            end
        end
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
`ifdef SUB_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
`ifdef SUB_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
`ifdef SUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_prefix_subtractor_pipe.sv
// Bench for prefix_subtractor_pipe at SIZE=8, LEVEL=3.
// Optional feature macro: SUB_OVF_EN (ovf port connected and checked).
module tb_prefix_subtractor_pipe;

    localparam int SIZE  = 8;
    localparam int LEVEL = 3;
`ifdef SUB_OVF_EN
    localparam logic [9:0] CMP_MASK = 10'h3FF;
`else
    localparam logic [9:0] CMP_MASK = 10'h1FF;
`endif

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE:1]   a;
    logic [SIZE:1]   b;
    logic            bin;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE:1]   diff;
    logic            bout;
    logic            ovf_s;
`ifdef SUB_OVF_EN
    logic            ovf;
    assign ovf_s = ovf;
`else
    assign ovf_s = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_cyc = 0;
    int lat;
    logic rnd_done;
    logic [7:0] rx, ry;
    logic       rc;

    // Expected {ovf, bout, diff} in acceptance order.
    logic [9:0] exp_q[$];

    prefix_subtractor_pipe #(
        .SIZE  (SIZE),
        .LEVEL (LEVEL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // Arithmetic reference: 9-bit two's complement a - b - bin plus signed overflow.
    function automatic logic [9:0] ref_model(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] r;
        logic       v;
        r = {1'b0, x} - {1'b0, y} - {8'd0, c};
        v = (x[7] ^ y[7]) & (x[7] ^ r[7]);
        return {v, r};
    endfunction

    // Driver: entered just after a rising edge; holds the operand until accepted.
    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                        input logic [9:0] texp);
        logic done;
        done     = 1'b0;
        a        = ta;
        b        = tb;
        bin      = tbin;
        in_valid = 1'b1;
        for (int w = 0; w < 200 && !done; w++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(texp);
                acc_cyc = cyc;
                done    = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 expected acceptance");
        end
    endtask

    task automatic wait_valid(output int l);
        l = -1;
        for (int w = 0; w < 30; w++) begin
            @(negedge clk);
            if (out_valid) begin
                l = cyc - acc_cyc;
                break;
            end
        end
    endtask

    task automatic drain();
        for (int w = 0; w < 400; w++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Scoreboard monitor: front of queue must be presented while valid; pop on handshake.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got %0h expected none", {ovf_s, bout, diff});
            end else begin
                check("result", {ovf_s, bout, diff} & CMP_MASK, exp_q[0] & CMP_MASK);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Directed vectors with hand-computed {ovf, bout, diff}.
    logic [7:0] tv_a   [0:7] = '{8'h03, 8'h00, 8'h80, 8'h7F, 8'hFF, 8'h00, 8'h80, 8'hFF};
    logic [7:0] tv_b   [0:7] = '{8'h05, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
    logic       tv_bin [0:7] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
    logic [9:0] tv_exp [0:7] = '{10'h1FE, 10'h1FF, 10'h27F, 10'h380,
                                 10'h1FF, 10'h101, 10'h27F, 10'h0FF};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b1;
        rnd_done  = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_diff", diff, 0);
        check("reset_bout", bout, 0);
        check("reset_ovf", ovf_s, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;

        // Basic subtraction with latency.
        send(8'h05, 8'h03, 1'b0, 10'h002);
        wait_valid(lat);
        check("latency_basic", lat, LEVEL + 2);
        drain();

        // Underflow, borrow-in, signed overflow, extremes (back-to-back).
        for (int i = 0; i < 8; i++) send(tv_a[i], tv_b[i], tv_bin[i], tv_exp[i]);
        drain();

        // Backpressure: 8 back-to-back inputs, 3-cycle stall at first out_valid.
        fork
            begin
                for (int k = 1; k <= 8; k++)
                    send(8'(k), 8'h01, 1'b0, {2'b00, 8'(k - 1)});
            end
            begin
                for (int w = 0; w < 40; w++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid) break;
                end
                check("bp_first_valid", out_valid, 1);
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    check("bp_in_ready_low", in_ready, 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-flight: 4 accepted, then reset together with a new input.
        for (int k = 0; k < 4; k++) send(8'(8'h20 + k), 8'h01, 1'b0, {2'b00, 8'(8'h1F + k)});
        rst      = 1'b1;
        a        = 8'h55;
        b        = 8'h01;
        bin      = 1'b0;
        in_valid = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("in_ready_after_midreset", in_ready, 1);
        for (int w = 0; w < 10; w++) begin
            @(negedge clk);
            check("no_valid_after_reset", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(8'h10, 8'h01, 1'b0, 10'h00F);
        wait_valid(lat);
        check("latency_after_reset", lat, LEVEL + 2);
        drain();

        // Random operands with random backpressure and input bubbles.
        fork
            begin
                for (int n = 0; n < 4000; n++) begin
                    rx = 8'($urandom_range(0, 255));
                    ry = 8'($urandom_range(0, 255));
                    rc = 1'($urandom_range(0, 1));
                    send(rx, ry, rc, ref_model(rx, ry, rc));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
